// File: rtl/tx_gearbox_6466b.sv
// 64b/66b transmit gearbox: packs 66-bit blocks into a continuous DATA_WIDTH-bit line stream.
// Optional TX_GEARBOX_HDR_CHECK_EN adds o_header_err for invalid sync headers.
module tx_gearbox_6466b #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  i_txc,
    input  logic                  i_reset,
    input  logic                  i_init_done,
    input  logic [DATA_WIDTH-1:0] i_txd,
    input  logic [1:0]            i_tx_header,
    output logic                  o_tx_pause,
    output logic [DATA_WIDTH-1:0] o_txd,
    output logic [5:0]            o_tx_sequence
`ifdef TX_GEARBOX_HDR_CHECK_EN
    ,
    output logic                  o_header_err
`endif
);

    localparam int unsigned CW         = DATA_WIDTH + 64;
    localparam logic [5:0]  PAUSE_SLOT = 6'd32;
    localparam logic [6:0]  W7         = 7'(DATA_WIDTH);
    localparam logic        FULL       = (DATA_WIDTH == 64);

    generate
        if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
            $error("tx_gearbox_6466b: DATA_WIDTH must be 32 or 64");
        end
    endgenerate

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                  state_q, state_n;
    logic [63:0]             buf_q, buf_n;
    logic [6:0]              res_q, res_n;
    logic                    phase_q, phase_n;
    logic [5:0]              seq_n;
    logic                    pause_n;
    logic [DATA_WIDTH-1:0]   txd_n;
    logic                    has_hdr, slot_end, accept;
    logic [CW-1:0]           in_ext, comb;

    always_comb begin
        state_n  = state_q;
        buf_n    = buf_q;
        res_n    = res_q;
        phase_n  = phase_q;
        seq_n    = o_tx_sequence;
        pause_n  = o_tx_pause;
        txd_n    = '0;
        has_hdr  = FULL | ~phase_q;
        slot_end = FULL | phase_q;
        accept   = 1'b0;
        in_ext   = '0;
        comb     = '0;
        if (!i_init_done) begin
            state_n = IDLE;
            buf_n   = '0;
            res_n   = '0;
            phase_n = 1'b0;
            seq_n   = '0;
            pause_n = 1'b1;
        end else if (state_q == IDLE) begin
            state_n = ACTIVE;
            buf_n   = '0;
            res_n   = '0;
            phase_n = 1'b0;
            seq_n   = '0;
            pause_n = 1'b0;
        end else begin
            accept = ~o_tx_pause;
            if (accept) begin
                if (has_hdr) in_ext[DATA_WIDTH+1:0] = {i_txd, i_tx_header};
                else         in_ext[DATA_WIDTH-1:0] = i_txd;
            end
            // New bits land directly above the residual; the low word goes out, the rest is kept.
            comb  = CW'(buf_q) | (in_ext << res_q);
            txd_n = comb[DATA_WIDTH-1:0];
            buf_n = comb[CW-1:DATA_WIDTH];
            if (accept) res_n = res_q + (has_hdr ? 7'd2 : 7'd0);
            else        res_n = res_q - W7;
            phase_n = ~phase_q;
            if (slot_end)
                seq_n = (o_tx_sequence == PAUSE_SLOT) ? 6'd0 : o_tx_sequence + 6'd1;
            pause_n = (seq_n == PAUSE_SLOT);
        end
    end

    always_ff @(posedge i_txc or posedge i_reset) begin
        if (i_reset) begin
            state_q       <= IDLE;
            buf_q         <= '0;
            res_q         <= '0;
            phase_q       <= 1'b0;
            o_tx_sequence <= '0;
            o_tx_pause    <= 1'b1;
            o_txd         <= '0;
        end else begin
            state_q       <= state_n;
            buf_q         <= buf_n;
            res_q         <= res_n;
            phase_q       <= phase_n;
            o_tx_sequence <= seq_n;
            o_tx_pause    <= pause_n;
            o_txd         <= txd_n;
        end
    end

`ifdef TX_GEARBOX_HDR_CHECK_EN
    logic err_n, pend_q, pend_n;

    // A header sitting above the first output word is flagged one cycle later, when it leaves.
    always_comb begin
        err_n  = 1'b0;
        pend_n = 1'b0;
        if (state_q == ACTIVE && i_init_done) begin
            err_n = pend_q;
            if (accept && has_hdr && (i_tx_header == 2'b00 || i_tx_header == 2'b11)) begin
                if (res_q < W7) err_n  = 1'b1;
                else            pend_n = 1'b1;
            end
        end
    end

    always_ff @(posedge i_txc or posedge i_reset) begin
        if (i_reset) begin
            o_header_err <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            o_header_err <= err_n;
            pend_q       <= pend_n;
        end
    end
`endif

endmodule

// File: tb/tb_tx_gearbox_6466b.sv
// Self-checking bench for tx_gearbox_6466b at widths 64 and 32 against a bit-queue stream model.
module tb_tx_gearbox_6466b;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic        init64, init32;
    logic [63:0] txd64_in;
    logic [1:0]  hdr64;
    logic        pause64;
    logic [63:0] txd64;
    logic [5:0]  seq64;
    logic [31:0] txd32_in;
    logic [1:0]  hdr32;
    logic        pause32;
    logic [31:0] txd32;
    logic [5:0]  seq32;
`ifdef TX_GEARBOX_HDR_CHECK_EN
    logic        err64, err32;
`endif

    int unsigned checks = 0;
    int unsigned errors = 0;
    bit          exp_q[$];

    tx_gearbox_6466b #(.DATA_WIDTH(64)) dut64 (
        .i_txc(clk), .i_reset(rst), .i_init_done(init64),
        .i_txd(txd64_in), .i_tx_header(hdr64),
        .o_tx_pause(pause64), .o_txd(txd64), .o_tx_sequence(seq64)
`ifdef TX_GEARBOX_HDR_CHECK_EN
        , .o_header_err(err64)
`endif
    );

    tx_gearbox_6466b #(.DATA_WIDTH(32)) dut32 (
        .i_txc(clk), .i_reset(rst), .i_init_done(init32),
        .i_txd(txd32_in), .i_tx_header(hdr32),
        .o_tx_pause(pause32), .o_txd(txd32), .o_tx_sequence(seq32)
`ifdef TX_GEARBOX_HDR_CHECK_EN
        , .o_header_err(err32)
`endif
    );

    task automatic test_reset();
        init64 = 1'b0; init32 = 1'b0;
        txd64_in = '0; hdr64 = 2'b01; txd32_in = '0; hdr32 = 2'b01;
        #1 rst = 1'b1;
        #1;
        checks++; if (pause64 !== 1'b1) begin errors++; $display("FAIL reset_pause64 got %b exp 1", pause64); end
        checks++; if (seq64 !== 6'd0) begin errors++; $display("FAIL reset_seq64 got %0d exp 0", seq64); end
        checks++; if (txd64 !== 64'd0) begin errors++; $display("FAIL reset_txd64 got %h exp 0", txd64); end
        checks++; if (pause32 !== 1'b1) begin errors++; $display("FAIL reset_pause32 got %b exp 1", pause32); end
        checks++; if (seq32 !== 6'd0) begin errors++; $display("FAIL reset_seq32 got %0d exp 0", seq32); end
        checks++; if (txd32 !== 32'd0) begin errors++; $display("FAIL reset_txd32 got %h exp 0", txd32); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            checks++; if (pause64 !== 1'b1 || txd64 !== 64'd0 || seq64 !== 6'd0) begin
                errors++; $display("FAIL idle64 got pause=%b txd=%h seq=%0d exp 1/0/0", pause64, txd64, seq64);
            end
        end
    endtask

    // mode 0: zero payload hdr 01; 1: all-ones hdr 10; 2: random; 3: random with bad header on block 5
    task automatic test_stream64(input int mode, input int ncycles);
        logic [63:0] expw, pay;
        logic [1:0]  hdr;
        logic        exp_pause;
        int          exp_seq;
        exp_q.delete();
        @(posedge clk); #1 init64 = 1'b1;
        for (int c = 0; c < ncycles; c++) begin
            @(posedge clk); #1;
            exp_pause = ((c % 33) == 32);
            exp_seq   = c % 33;
            checks++; if (pause64 !== exp_pause) begin errors++; $display("FAIL pause64 c=%0d got %b exp %b", c, pause64, exp_pause); end
            checks++; if (seq64 !== 6'(exp_seq)) begin errors++; $display("FAIL seq64 c=%0d got %0d exp %0d", c, seq64, exp_seq); end
            if (c == 0) begin
                checks++; if (txd64 !== 64'd0) begin errors++; $display("FAIL first_active_txd64 got %h exp 0", txd64); end
            end else if (exp_q.size() < 64) begin
                checks++; errors++; $display("FAIL model_underflow64 c=%0d got %0d bits exp 64", c, exp_q.size());
            end else begin
                for (int i = 0; i < 64; i++) expw[i] = exp_q.pop_front();
                checks++; if (txd64 !== expw) begin errors++; $display("FAIL stream64 c=%0d got %h exp %h", c, txd64, expw); end
            end
            if (mode == 0 && c == 1) begin
                checks++; if (txd64 !== 64'h0000_0000_0000_0001) begin errors++; $display("FAIL zero_first got %h exp 0000000000000001", txd64); end
            end
            if (mode == 1 && c == 1) begin
                checks++; if (txd64 !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL ones_first got %h exp FFFFFFFFFFFFFFFE", txd64); end
            end
            if (mode == 1 && c == 2) begin
                checks++; if (txd64 !== 64'hFFFF_FFFF_FFFF_FFFB) begin errors++; $display("FAIL ones_second got %h exp FFFFFFFFFFFFFFFB", txd64); end
            end
`ifdef TX_GEARBOX_HDR_CHECK_EN
            if (mode == 3) begin
                checks++; if (err64 !== (c == 6)) begin errors++; $display("FAIL header_err c=%0d got %b exp %b", c, err64, (c == 6)); end
            end
`endif
            if (exp_pause) begin
                txd64_in = 64'hDEAD_BEEF_0000_0000;
                hdr64    = 2'($urandom);
            end else begin
                case (mode)
                    0: begin hdr = 2'b01; pay = '0; end
                    1: begin hdr = 2'b10; pay = '1; end
                    default: begin hdr = 2'($urandom_range(1, 2)); pay = {$urandom, $urandom}; end
                endcase
                if (mode == 3 && c == 5) hdr = 2'b11;
                txd64_in = pay; hdr64 = hdr;
                exp_q.push_back(hdr[0]); exp_q.push_back(hdr[1]);
                for (int i = 0; i < 64; i++) exp_q.push_back(pay[i]);
            end
            if (c == ncycles - 1) init64 = 1'b0;
        end
        @(posedge clk); #1;
        checks++; if (pause64 !== 1'b1 || seq64 !== 6'd0 || txd64 !== 64'd0) begin
            errors++; $display("FAIL drop_idle64 got pause=%b seq=%0d txd=%h exp 1/0/0", pause64, seq64, txd64);
        end
    endtask

    task automatic test_stream32(input int ncycles);
        logic [63:0] pay, pay0;
        logic [1:0]  hdr, hdr0;
        logic [31:0] expw;
        logic        exp_pause;
        int          exp_seq;
        exp_q.delete();
        pay = '0; hdr = 2'b01; pay0 = '0; hdr0 = 2'b01;
        @(posedge clk); #1 init32 = 1'b1;
        for (int c = 0; c < ncycles; c++) begin
            @(posedge clk); #1;
            exp_pause = ((c % 66) >= 64);
            exp_seq   = (c % 66) / 2;
            checks++; if (pause32 !== exp_pause) begin errors++; $display("FAIL pause32 c=%0d got %b exp %b", c, pause32, exp_pause); end
            checks++; if (seq32 !== 6'(exp_seq)) begin errors++; $display("FAIL seq32 c=%0d got %0d exp %0d", c, seq32, exp_seq); end
            if (c == 0) begin
                checks++; if (txd32 !== 32'd0) begin errors++; $display("FAIL first_active_txd32 got %h exp 0", txd32); end
            end else if (exp_q.size() < 32) begin
                checks++; errors++; $display("FAIL model_underflow32 c=%0d got %0d bits exp 32", c, exp_q.size());
            end else begin
                for (int i = 0; i < 32; i++) expw[i] = exp_q.pop_front();
                checks++; if (txd32 !== expw) begin errors++; $display("FAIL stream32 c=%0d got %h exp %h", c, txd32, expw); end
            end
            if (c == 1) begin
                checks++; if (txd32 !== {pay0[29:0], hdr0}) begin errors++; $display("FAIL w32_first got %h exp %h", txd32, {pay0[29:0], hdr0}); end
            end
            if (exp_pause) begin
                txd32_in = 32'hDEAD_BEEF;
                hdr32    = 2'($urandom);
            end else if ((c % 2) == 0) begin
                hdr = 2'($urandom_range(1, 2));
                pay = {$urandom, $urandom};
                if (c == 0) begin pay0 = pay; hdr0 = hdr; end
                txd32_in = pay[31:0]; hdr32 = hdr;
                exp_q.push_back(hdr[0]); exp_q.push_back(hdr[1]);
                for (int i = 0; i < 32; i++) exp_q.push_back(pay[i]);
            end else begin
                txd32_in = pay[63:32]; hdr32 = 2'($urandom);
                for (int i = 32; i < 64; i++) exp_q.push_back(pay[i]);
            end
            if (c == ncycles - 1) init32 = 1'b0;
        end
        @(posedge clk); #1;
        checks++; if (pause32 !== 1'b1 || seq32 !== 6'd0 || txd32 !== 32'd0) begin
            errors++; $display("FAIL drop_idle32 got pause=%b seq=%0d txd=%h exp 1/0/0", pause32, seq32, txd32);
        end
    endtask

    task automatic test_async_reset();
        @(posedge clk); #1 init64 = 1'b1; hdr64 = 2'b10;
        for (int c = 0; c <= 17; c++) begin
            @(posedge clk); #1;
            txd64_in = {$urandom, $urandom};
        end
        checks++; if (seq64 !== 6'd17) begin errors++; $display("FAIL pre_reset_seq got %0d exp 17", seq64); end
        #3 rst = 1'b1;
        #1;
        checks++; if (pause64 !== 1'b1) begin errors++; $display("FAIL async_pause got %b exp 1", pause64); end
        checks++; if (seq64 !== 6'd0) begin errors++; $display("FAIL async_seq got %0d exp 0", seq64); end
        checks++; if (txd64 !== 64'd0) begin errors++; $display("FAIL async_txd got %h exp 0", txd64); end
        init64 = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_stream64(0, 33);
        test_stream64(1, 165);
        test_stream64(2, 99);
        test_stream32(198);
        test_async_reset();
        test_stream64(2, 66);
`ifdef TX_GEARBOX_HDR_CHECK_EN
        test_stream64(3, 12);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
